// File: rtl/mips_pkg.sv
// Shared constants and types for the memory stage.
package mips_pkg;

   localparam int REG_W  = 5;
   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;

   localparam logic [DATA_W-1:0] ADDR_BASE_DEF = 32'd1024;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mem_state_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// BUSY-cycle watchdog for the memory stage (only built with MEM_TIMEOUT_EN).
// Down-counter reloaded when a transaction starts; expired pulses in the
// BUSY cycle that reaches the terminal count.
module mem_timeout_counter #(
   parameter int CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [CNT_W-1:0] count;

   // reload on transaction start, count down while BUSY, park at zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= CNT_W'(CYCLES - 1);
      end else if (en && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign expired = en && (count == '0);

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: ALU results pass straight through with one cycle of
// latency, loads/stores run a single outstanding request against the data
// memory while freezing the upstream stages.
// Optional feature macro: MEM_TIMEOUT_EN (abort BUSY after TIMEOUT_CYCLES).
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | accept next op; ALU ops go to wb_*, memory ops latch and start
//  BUSY  | mem_req held, waiting for mem_ack (or timeout)
//  DONE  | request finished, wb_* loaded from the latched op on this edge
module mem_stage
   import mips_pkg::*;
#(
   parameter int                TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0] ADDR_BASE      = ADDR_BASE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] st_value,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   input  logic              wb_en_in,
   input  logic [REG_W-1:0]  dest_in,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              freeze,
   output logic              wb_en,
   output logic              wb_mem_r_en,
   output logic [DATA_W-1:0] wb_alu_result,
   output logic [DATA_W-1:0] wb_mem_data,
   output logic [REG_W-1:0]  wb_dest,
   output logic              mem_err
);

   mem_state_t state_q, state_d;

   logic              mem_op;
   logic              start;
   logic              timeout_hit;
   logic [ADDR_W-1:0] word_addr;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic              ld_q;
   logic              wben_q;
   logic [REG_W-1:0]  dest_q;
   logic [DATA_W-1:0] alu_q;
   logic [DATA_W-1:0] rdata_q;

   assign mem_op    = mem_r_en | mem_w_en;
   assign start     = (state_q == ST_IDLE) && mem_op;
   // low two bits dropped; subtraction is allowed to wrap
   assign word_addr = ADDR_W'((alu_result - ADDR_BASE) >> 2);

   assign mem_we    = (state_q == ST_BUSY) && we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

`ifdef MEM_TIMEOUT_EN
   logic err_q;

   mem_timeout_counter #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .load    (start),
      .en      (state_q == ST_BUSY),
      .expired (timeout_hit)
   );

   // sticky error once a request is abandoned for lack of ack
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if ((state_q == ST_BUSY) && !mem_ack && timeout_hit) begin
         err_q <= 1'b1;
      end
   end

   assign mem_err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign mem_err     = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next state, request and freeze; an ack in the last BUSY cycle beats the timeout
   always_comb begin
      state_d = state_q;
      freeze  = 1'b0;
      mem_req = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (mem_op) begin
               freeze  = 1'b1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            freeze  = 1'b1;
            mem_req = 1'b1;
            if (mem_ack || timeout_hit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // latch the memory op at start, capture read data on ack
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         ld_q    <= 1'b0;
         wben_q  <= 1'b0;
         dest_q  <= '0;
         alu_q   <= '0;
         rdata_q <= '0;
      end else if (start) begin
         addr_q  <= word_addr;
         wdata_q <= st_value;
         we_q    <= mem_w_en;
         ld_q    <= mem_r_en & ~mem_w_en;
         wben_q  <= wb_en_in;
         dest_q  <= dest_in;
         alu_q   <= alu_result;
         rdata_q <= '0;
      end else if ((state_q == ST_BUSY) && mem_ack) begin
         rdata_q <= ld_q ? mem_rdata : '0;
      end
   end

   // writeback register: pass ALU ops, bubble while frozen, retire memory ops from DONE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_en         <= 1'b0;
         wb_mem_r_en   <= 1'b0;
         wb_alu_result <= '0;
         wb_mem_data   <= '0;
         wb_dest       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mem_op) begin
                  wb_en       <= 1'b0;
                  wb_mem_r_en <= 1'b0;
               end else begin
                  wb_en         <= wb_en_in;
                  wb_mem_r_en   <= 1'b0;
                  wb_alu_result <= alu_result;
                  wb_mem_data   <= '0;
                  wb_dest       <= dest_in;
               end
            end
            ST_BUSY: begin
               wb_en       <= 1'b0;
               wb_mem_r_en <= 1'b0;
            end
            ST_DONE: begin
               wb_en         <= wben_q;
               wb_mem_r_en   <= ld_q;
               wb_alu_result <= alu_q;
               wb_mem_data   <= rdata_q;
               wb_dest       <= dest_q;
            end
            default: begin
               wb_en       <= 1'b0;
               wb_mem_r_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: operation-level timeline model plus directed checks.
module tb_mem_stage;
   import mips_pkg::*;

   localparam int          TO   = 4;
   localparam logic [31:0] BASE = 32'd1024;

   logic        clk, rst;
   logic [31:0] alu_result, st_value, mem_rdata;
   logic        mem_r_en, mem_w_en, wb_en_in, mem_ack;
   logic [4:0]  dest_in;
   logic        mem_req, mem_we, freeze, wb_en, wb_mem_r_en, mem_err;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata, wb_alu_result, wb_mem_data;
   logic [4:0]  wb_dest;

   mem_stage #(.TIMEOUT_CYCLES(TO), .ADDR_BASE(BASE)) dut (
      .clk(clk), .rst(rst),
      .alu_result(alu_result), .st_value(st_value),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .wb_en_in(wb_en_in), .dest_in(dest_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .freeze(freeze), .wb_en(wb_en), .wb_mem_r_en(wb_mem_r_en),
      .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
      .wb_dest(wb_dest), .mem_err(mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // model: last retired op and whether it retired on the most recent edge
   logic        rec_wben, rec_ld, show, err_m;
   logic [4:0]  rec_dest;
   logic [31:0] rec_alu, rec_data;

   logic        chk_on;
   logic        exp_freeze, exp_req, exp_we;
   logic        exp_wb_en, exp_wb_r, exp_err;
   logic [29:0] exp_addr;
   logic [31:0] exp_wdata, exp_alu, exp_data;
   logic [4:0]  exp_dest;

   int          frz_seen, req_seen;
   logic [29:0] seen_addr;
   logic        seen_we;
   logic [31:0] seen_wdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("freeze",        32'(freeze),        32'(exp_freeze));
         chk("mem_req",       32'(mem_req),       32'(exp_req));
         chk("mem_we",        32'(mem_we),        32'(exp_req & exp_we));
         if (exp_req) begin
            chk("mem_addr",  32'(mem_addr),  32'(exp_addr));
            chk("mem_wdata", mem_wdata,      exp_wdata);
         end
         chk("wb_en",         32'(wb_en),         32'(exp_wb_en));
         chk("wb_mem_r_en",   32'(wb_mem_r_en),   32'(exp_wb_r));
         chk("wb_dest",       32'(wb_dest),       32'(exp_dest));
         chk("wb_alu_result", wb_alu_result,      exp_alu);
         chk("wb_mem_data",   wb_mem_data,        exp_data);
         chk("mem_err",       32'(mem_err),       32'(exp_err));
         if (freeze) frz_seen++;
         if (mem_req) begin
            req_seen++;
            seen_addr  = mem_addr;
            seen_we    = mem_we;
            seen_wdata = mem_wdata;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wb();
      exp_wb_en = show ? rec_wben : 1'b0;
      exp_wb_r  = show ? rec_ld   : 1'b0;
      exp_dest  = rec_dest;
      exp_alu   = rec_alu;
      exp_data  = rec_data;
      exp_err   = err_m;
   endtask

   task automatic scramble();
      mem_r_en   = 1'($urandom % 2);
      mem_w_en   = 1'($urandom % 2);
      wb_en_in   = 1'($urandom % 2);
      dest_in    = 5'($urandom);
      alu_result = $urandom;
      st_value   = $urandom;
   endtask

   task automatic run_alu(input logic wben, input logic [4:0] dest,
                          input logic [31:0] alu, input logic ack);
      mem_r_en = 1'b0; mem_w_en = 1'b0;
      wb_en_in = wben; dest_in = dest; alu_result = alu; st_value = $urandom;
      mem_ack = ack; mem_rdata = $urandom;
      set_wb();
      exp_freeze = 1'b0; exp_req = 1'b0;
      rec_wben = wben; rec_ld = 1'b0; rec_dest = dest; rec_alu = alu; rec_data = 32'd0;
      show = 1'b1;
      step();
   endtask

   // lat = BUSY cycle (1-based) in which the ack arrives
   task automatic run_mem(input logic ld, input logic st, input logic [31:0] alu,
                          input logic [31:0] sv, input logic wben, input logic [4:0] dest,
                          input int lat, input logic [31:0] rdata);
      logic        is_ld, to;
      int          busy;
      logic [31:0] cap;
      is_ld = ld & ~st;
      mem_r_en = ld; mem_w_en = st; wb_en_in = wben; dest_in = dest;
      alu_result = alu; st_value = sv;
      mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
      set_wb();
      exp_freeze = 1'b1; exp_req = 1'b0;
      show = 1'b0;
      step();
      busy = lat; to = 1'b0;
`ifdef MEM_TIMEOUT_EN
      if (lat > TO) begin busy = TO; to = 1'b1; end
`endif
      cap = 32'd0;
      for (int k = 1; k <= busy; k++) begin
         scramble();
         mem_ack   = (k == lat);
         mem_rdata = (k == lat) ? rdata : $urandom;
         set_wb();
         exp_freeze = 1'b1; exp_req = 1'b1; exp_we = st;
         exp_addr   = 30'((alu - BASE) / 4);
         exp_wdata  = sv;
         if (k == lat) cap = is_ld ? rdata : 32'd0;
         step();
      end
      scramble();
      mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
      if (to) err_m = 1'b1;
      set_wb();
      exp_freeze = 1'b0; exp_req = 1'b0;
      rec_wben = wben; rec_ld = is_ld; rec_dest = dest; rec_alu = alu; rec_data = cap;
      show = 1'b1;
      step();
   endtask

   task automatic model_reset();
      rec_wben = 1'b0; rec_ld = 1'b0; rec_dest = 5'd0; rec_alu = 32'd0; rec_data = 32'd0;
      show = 1'b0; err_m = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " mem_req"},       32'(mem_req),       32'd0);
      chk({tag, " mem_we"},        32'(mem_we),        32'd0);
      chk({tag, " mem_addr"},      32'(mem_addr),      32'd0);
      chk({tag, " mem_wdata"},     mem_wdata,          32'd0);
      chk({tag, " freeze"},        32'(freeze),        32'd0);
      chk({tag, " wb_en"},         32'(wb_en),         32'd0);
      chk({tag, " wb_mem_r_en"},   32'(wb_mem_r_en),   32'd0);
      chk({tag, " wb_alu_result"}, wb_alu_result,      32'd0);
      chk({tag, " wb_mem_data"},   wb_mem_data,        32'd0);
      chk({tag, " wb_dest"},       32'(wb_dest),       32'd0);
      chk({tag, " mem_err"},       32'(mem_err),       32'd0);
      chk({tag, " state"},         32'(dut.state_q),   32'(ST_IDLE));
   endtask

   initial begin
      chk_on = 1'b0;
      model_reset();
      exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
      frz_seen = 0; req_seen = 0;
      rst = 1'b0;
      alu_result = 32'd0; st_value = 32'd0; mem_rdata = 32'd0;
      mem_r_en = 1'b0; mem_w_en = 1'b0; wb_en_in = 1'b0; dest_in = 5'd0; mem_ack = 1'b0;
      repeat (3) step();
      chk_all_zero("reset");
      rst = 1'b1;
      chk_on = 1'b1;

      // ALU pass-through
      frz_seen = 0;
      run_alu(1'b1, 5'd5, 32'h0000_1234, 1'b1);
      chk("alu wb_en",  32'(wb_en),   32'd1);
      chk("alu wb_dest", 32'(wb_dest), 32'd5);
      chk("alu wb_alu_result", wb_alu_result, 32'h0000_1234);
      chk("alu freeze cycles", 32'(frz_seen), 32'd0);

      // load, ack in third BUSY cycle
      frz_seen = 0;
      run_mem(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, 5'd7, 3, 32'hDEAD_BEEF);
      chk("load freeze cycles", 32'(frz_seen), 32'd4);
      chk("load mem_addr", 32'(seen_addr), 32'd1);
      chk("load wb_mem_data", wb_mem_data, 32'hDEAD_BEEF);
      chk("load wb_mem_r_en", 32'(wb_mem_r_en), 32'd1);

      // store, ack in first BUSY cycle
      frz_seen = 0;
      run_mem(1'b0, 1'b1, 32'd1032, 32'hA5A5_A5A5, 1'b0, 5'd0, 1, 32'h1357_9BDF);
      chk("store freeze cycles", 32'(frz_seen), 32'd2);
      chk("store mem_addr", 32'(seen_addr), 32'd2);
      chk("store mem_we", 32'(seen_we), 32'd1);
      chk("store mem_wdata", seen_wdata, 32'hA5A5_A5A5);
      chk("store wb_mem_data", wb_mem_data, 32'd0);

      // both enables set behaves as a store; base minus one wraps
      run_mem(1'b1, 1'b1, 32'd1023, 32'h0BAD_F00D, 1'b1, 5'd9, 2, 32'hFFFF_0000);
      chk("both mem_we", 32'(seen_we), 32'd1);
      chk("wrap mem_addr", 32'(seen_addr), 32'h3FFF_FFFF);
      chk("both wb_mem_r_en", 32'(wb_mem_r_en), 32'd0);

      // back-to-back loads with immediate ack
      req_seen = 0;
      run_mem(1'b1, 1'b0, 32'd1032, 32'h0, 1'b1, 5'd3, 1, 32'h1111_1111);
      chk("b2b first data", wb_mem_data, 32'h1111_1111);
      run_mem(1'b1, 1'b0, 32'd1036, 32'h0, 1'b1, 5'd4, 1, 32'h2222_2222);
      chk("b2b second data", wb_mem_data, 32'h2222_2222);
      chk("b2b second dest", 32'(wb_dest), 32'd4);
      chk("b2b req cycles", 32'(req_seen), 32'd2);

`ifdef MEM_TIMEOUT_EN
      req_seen = 0;
      run_mem(1'b1, 1'b0, 32'd2000, 32'h0, 1'b1, 5'd9, 20, 32'hCAFE_CAFE);
      chk("timeout req cycles", 32'(req_seen), 32'd4);
      chk("timeout mem_err", 32'(mem_err), 32'd1);
      chk("timeout wb_mem_data", wb_mem_data, 32'd0);
      run_alu(1'b1, 5'd1, 32'd77, 1'b1);
      chk("timeout err sticky", 32'(mem_err), 32'd1);
`endif

      // randomized mix
      for (int i = 0; i < 200; i++) begin
         int unsigned sel;
         logic [31:0] a;
         sel = $urandom_range(9, 0);
         a   = ($urandom % 2 != 0) ? (BASE + ($urandom % 4096)) : $urandom;
         if (sel < 4) begin
            run_alu(1'($urandom % 2), 5'($urandom), a, 1'($urandom % 2));
         end else begin
            run_mem((sel <= 6) || (sel == 9), (sel >= 7), a, $urandom,
                    1'($urandom % 2), 5'($urandom), int'($urandom_range(6, 1)), $urandom);
         end
      end

      // reset in the second BUSY cycle abandons the load; later ack ignored
      mem_r_en = 1'b1; mem_w_en = 1'b0; wb_en_in = 1'b1; dest_in = 5'd3;
      alu_result = 32'd1040; st_value = 32'h0; mem_ack = 1'b0;
      set_wb();
      exp_freeze = 1'b1; exp_req = 1'b0; show = 1'b0;
      step();
      mem_ack = 1'b0;
      set_wb();
      exp_freeze = 1'b1; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 30'd4; exp_wdata = 32'h0;
      step();
      chk_on = 1'b0;
      rst = 1'b0;
      mem_r_en = 1'b0; wb_en_in = 1'b0; dest_in = 5'd0; alu_result = 32'd0;
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      #1;
      chk_all_zero("midbusy reset");
      step();
      rst = 1'b1;
      model_reset();
      chk_on = 1'b1;
      run_alu(1'b0, 5'd0, 32'd0, 1'b1);
      chk_all_zero("after reset ack");
      chk_on = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
